program_loader: RTL and testbench
=================================

# program_loader

Writes a program image into the instruction memory's write port from a byte stream, so the CPU can run new code without re-synthesising the memory's initial contents. It sits between a byte source (UART receiver or test host) and the instruction memory. It holds the CPU stalled while a load is in progress and releases it once the checksum has been verified.

## Interface
- TEXT_BASE, 32'h0040_0000: byte address of instruction word 0; must match the instruction memory's text base.
- DEPTH, 256: instruction memory depth in 32-bit words.
- clock  in  1  rising-edge system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte; a transfer occurs when byte_valid && byte_ready.
- mem_write  out  1  one-cycle write strobe to the instruction memory.
- mem_address  out  32  byte address of the word being written.
- mem_data  out  32  instruction word.
- cpu_hold  out  1  stalls the CPU (PC and register writes).
- done  out  1  last load succeeded.
- error  out  1  last load failed.

## Operation
- Stream format:
  - 2-byte little-endian word count N.
  - 4N payload bytes; each word is little-endian, word k goes to TEXT_BASE + 4k.
  - 1 checksum byte, equal to the XOR of all 4N payload bytes.
- States: IDLE, HDR0, HDR1, DATA, CHECK, DONE, ERROR.
- IDLE, DONE or ERROR with start=1 → HDR0; clear done, error, word index, byte index and checksum.
- start is ignored in HDR0, HDR1, DATA and CHECK.
- HDR0 → HDR1 on transfer (latch N[7:0]).
- HDR1 on transfer (latch N[15:8]):
  - N > DEPTH → ERROR, no writes.
  - N = 0 → CHECK.
  - Otherwise → DATA.
- DATA:
  - Each transfer shifts the byte into the word assembler and XORs it into the checksum.
  - On the 4th byte of a word, schedule a write; the word index increments after the write.
  - After word N-1 is assembled → CHECK.
- CHECK on transfer:
  - Byte equals running checksum → DONE.
  - Otherwise → ERROR.
- byte_ready is 1 only in HDR0, HDR1, DATA and CHECK.
- cpu_hold is 1 in HDR0 through CHECK and in ERROR; 0 in IDLE and DONE.
- done is 1 only in DONE; error is 1 only in ERROR.
- Writes already issued are never retracted on error; the memory contents are then undefined and the CPU stays held.
- Word index is 9 bits for DEPTH=256; mem_address = TEXT_BASE + {index, 2'b00}, computed with 32-bit wraparound.

## Timing
- Reset values:
  - State IDLE.
  - byte_ready, mem_write, cpu_hold, done, error = 0.
  - mem_address = TEXT_BASE; mem_data = 0.
- Reset asserted mid-load returns to IDLE immediately and asynchronously. Any pending write is dropped.
- mem_write is registered: high for exactly one cycle, the cycle after the 4th byte's transfer. mem_address and mem_data are stable during that cycle.
- Throughput is one byte per cycle; byte_ready stays high during the write cycle, so back-to-back words need no stall.
- byte_valid gaps of any length are allowed; state and partial word are held.
- The last word's write and the CHECK transfer may coincide. The write is still issued.
- State, done, error and cpu_hold change on the clock edge after the deciding transfer:
  - start → cpu_hold = 1 one cycle later.
  - Checksum byte accepted → done = 1 and cpu_hold = 0 one cycle later.

## Structure
- Shared package `loader_pkg`: state enum, TEXT_BASE default, header size (2) and checksum length (1).
- Sub-module `word_assembler`: 4-byte little-endian shift register with a 2-bit byte counter and a word_valid pulse. The FSM, index counter and checksum stay in the top level.

## Test plan
- Two-word load:
  - start, then bytes 02 00 37 04 01 10 83 24 44 00 C1.
  - Response: writes 0x10010437 @0x00400000 and 0x00442483 @0x00400004, one cycle each; done = 1, cpu_hold = 0, error = 0.
- Bad checksum: same stream with C0 as the last byte → both writes occur; error = 1, cpu_hold = 1, byte_ready = 0.
- Oversize header: bytes 01 01 (N = 257) → error = 1 after the second byte; no mem_write pulse ever.
- Empty load: bytes 00 00 00 → done = 1, no writes.
- Irregular source: the two-word stream with byte_valid dropped for 1–5 random cycles between bytes → identical writes and result.
- Reset and restart:
  - reset_n pulsed low after the 6th byte → all outputs at reset values the same cycle; no further writes.
  - A new start plus the full stream then completes with done = 1.
  - start pulses during DATA are ignored.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared definitions for the program loader
// Purpose: state encoding, default text base and stream framing sizes
//          shared by program_loader and its bench.
package loader_pkg;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam int          HDR_BYTES         = 2;
    localparam int          CHK_BYTES         = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - 4-byte little-endian word assembler
// Purpose: collects four stream bytes into one 32-bit word, first byte in
//          bits [7:0], and pulses word_valid the cycle after the 4th byte.
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   clear            restart assembly at byte 0 (start of a new load)
//   shift            accept byte_in this cycle
//   byte_in          data byte
//   word             assembled word, held until the next shift
//   byte_count       bytes already collected in the current word
//   word_valid       one-cycle pulse while word holds a completed word
module word_assembler (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  byte_count,
    output logic        word_valid
);

    logic [31:0] shreg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            byte_count <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= shift && (byte_count == 2'd3);
            if (clear) begin
                shreg      <= '0;
                byte_count <= '0;
            end else if (shift) begin
                // New bytes enter at the top so that after four shifts the
                // first byte received sits in the least significant lane.
                shreg      <= {byte_in, shreg[31:8]};
                byte_count <= byte_count + 2'd1;
            end
        end
    end

    assign word = shreg;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader for instruction memory
// Purpose: parses [count lo, count hi, 4N payload bytes, xor checksum] and
//          writes each word to TEXT_BASE + 4k, holding the CPU meanwhile.
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   start                     one-cycle pulse, honoured in IDLE/DONE/ERROR
//   byte_in/valid/ready       byte stream handshake
//   mem_write/address/data    instruction memory write port
//   cpu_hold                  CPU stall during load and after failure
//   done, error               result of the last load
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEFAULT,
    parameter int          DEPTH     = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int          IDX_W     = $clog2(DEPTH) + 1;
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    state_t             state;
    logic [15:0]        word_count;
    logic [IDX_W-1:0]   index;
    logic [7:0]         checksum;
    logic [1:0]         asm_byte_count;
    logic               transfer;
    logic               load_start;
    logic               asm_shift;
    logic               last_word;
    logic [15:0]        header_count;

    assign byte_ready = (state == ST_HDR0) || (state == ST_HDR1) ||
                        (state == ST_DATA) || (state == ST_CHECK);
    assign transfer   = byte_valid && byte_ready;
    assign load_start = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                  (state == ST_ERROR));
    assign asm_shift  = transfer && (state == ST_DATA);
    assign header_count = {byte_in, word_count[7:0]};
    // index still names the word being assembled: its increment from the
    // previous word's write lands well before this word's 4th byte.
    assign last_word  = ({{(16-IDX_W){1'b0}}, index} == (word_count - 16'd1));

    word_assembler u_asm (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (load_start),
        .shift      (asm_shift),
        .byte_in    (byte_in),
        .word       (mem_data),
        .byte_count (asm_byte_count),
        .word_valid (mem_write)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state      <= ST_HDR0;
                        word_count <= '0;
                        checksum   <= '0;
                    end
                end
                ST_HDR0: begin
                    if (transfer) begin
                        word_count[7:0] <= byte_in;
                        state           <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (transfer) begin
                        word_count <= header_count;
                        if ({1'b0, header_count} > DEPTH_LIM)
                            state <= ST_ERROR;
                        else if (header_count == 16'd0)
                            state <= ST_CHECK;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (transfer) begin
                        checksum <= checksum ^ byte_in;
                        if ((asm_byte_count == 2'd3) && last_word)
                            state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (transfer)
                        state <= (byte_in == checksum) ? ST_DONE : ST_ERROR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            index <= '0;
        else if (load_start)
            index <= '0;
        else if (mem_write)
            index <= index + 1'b1;
    end

    assign mem_address = TEXT_BASE + {{(30-IDX_W){1'b0}}, index, 2'b00};
    assign cpu_hold    = (state != ST_IDLE) && (state != ST_DONE);
    assign done        = (state == ST_DONE);
    assign error       = (state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

    typedef logic [7:0] u8_t;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 256;

    logic        clock = 0;
    logic        reset_n = 0;
    logic        start = 0;
    logic [7:0]  byte_in = 0;
    logic        byte_valid = 0;
    logic        byte_ready, mem_write, cpu_hold, done, error;
    logic [31:0] mem_address, mem_data;

    int checks = 0;
    int failures = 0;

    program_loader #(.TEXT_BASE(BASE), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position in the byte stream since start.
    bit          m_active = 0, m_done = 0, m_error = 0, m_wpend = 0;
    int          m_pos = 0, m_n = 0;
    logic [7:0]  m_xor = 0;
    logic [31:0] m_word = 0, m_waddr = 0, m_wdata = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_done = 0; m_error = 0; m_wpend = 0;
            m_pos = 0; m_n = 0; m_xor = 0;
        end else begin
            m_wpend = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_done = 0; m_error = 0;
                    m_pos = 0; m_n = 0; m_xor = 0;
                end
            end else if (byte_valid) begin
                if (m_pos == 0) begin
                    m_n = int'(byte_in);
                end else if (m_pos == 1) begin
                    m_n = m_n + 256 * int'(byte_in);
                    if (m_n > DEPTH) begin
                        m_active = 0; m_error = 1;
                    end
                end else if (m_pos < 2 + 4 * m_n) begin
                    int k;
                    k = m_pos - 2;
                    m_xor = m_xor ^ byte_in;
                    m_word[8*(k%4) +: 8] = byte_in;
                    if (k % 4 == 3) begin
                        m_wpend = 1;
                        m_waddr = BASE + 32'(4 * (k / 4));
                        m_wdata = m_word;
                    end
                end else begin
                    m_active = 0;
                    if (byte_in == m_xor) m_done = 1;
                    else m_error = 1;
                end
                m_pos++;
            end
        end
    end

    logic [63:0] wlog[$];

    always @(negedge clock) begin
        if (reset_n) begin
            chk("byte_ready", 32'(byte_ready), 32'(m_active));
            chk("cpu_hold", 32'(cpu_hold), 32'(m_active || m_error));
            chk("done", 32'(done), 32'(m_done));
            chk("error", 32'(error), 32'(m_error));
            chk("mem_write", 32'(mem_write), 32'(m_wpend));
            if (m_wpend) begin
                chk("mem_address", mem_address, m_waddr);
                chk("mem_data", mem_data, m_wdata);
            end
            if (mem_write) wlog.push_back({mem_address, mem_data});
        end
    end

    task automatic do_start();
        start = 1;
        @(posedge clock); #1;
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        byte_in = b;
        byte_valid = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (byte_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clock); #1;
        byte_valid = 0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=byte_ready_low required=accept byte %h", b);
        end
    endtask

    task automatic send_stream(input u8_t q[$], input int maxgap);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (maxgap > 0 && i != q.size() - 1)
                repeat ($urandom_range(maxgap, 1)) begin @(posedge clock); #1; end
        end
    endtask

    task automatic build(input logic [31:0] w[$], input bit bad, output u8_t q[$]);
        logic [15:0] n16;
        logic [7:0]  x;
        logic [31:0] wd;
        n16 = 16'(w.size());
        x = 0;
        q = {};
        q.push_back(n16[7:0]);
        q.push_back(n16[15:8]);
        foreach (w[i]) begin
            wd = w[i];
            for (int j = 0; j < 4; j++) begin
                q.push_back(wd[8*j +: 8]);
                x = x ^ wd[8*j +: 8];
            end
        end
        q.push_back(bad ? (x ^ 8'h5A) : x);
    endtask

    task automatic check_two_word(input string tag, input int lb);
        chk({tag, "_wcount"}, 32'(wlog.size() - lb), 32'd2);
        if (wlog.size() - lb == 2) begin
            chk({tag, "_addr0"}, wlog[lb][63:32], 32'h0040_0000);
            chk({tag, "_data0"}, wlog[lb][31:0], 32'h1001_0437);
            chk({tag, "_addr1"}, wlog[lb+1][63:32], 32'h0040_0004);
            chk({tag, "_data1"}, wlog[lb+1][31:0], 32'h0044_2483);
        end
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        u8_t         tw[$];
        u8_t         q[$];
        logic [31:0] w[$];
        int          lb, n;
        bit          bad;

        tw = '{8'h02, 8'h00, 8'h37, 8'h04, 8'h01, 8'h10, 8'h83, 8'h24, 8'h44, 8'h00, 8'hC1};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_byte_ready", 32'(byte_ready), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_cpu_hold", 32'(cpu_hold), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_mem_address", mem_address, BASE);
        chk("rst_mem_data", mem_data, 0);
        reset_n = 1;
        @(posedge clock); #1;

        // Two-word load
        lb = wlog.size();
        do_start();
        chk("start_hold", 32'(cpu_hold), 1);
        send_stream(tw, 0);
        @(negedge clock);
        chk("tw_done", 32'(done), 1);
        chk("tw_hold", 32'(cpu_hold), 0);
        chk("tw_error", 32'(error), 0);
        @(posedge clock); #1;
        check_two_word("tw", lb);

        // Bad checksum
        lb = wlog.size();
        q = tw;
        q[10] = 8'hC0;
        do_start();
        send_stream(q, 0);
        @(negedge clock);
        chk("bad_error", 32'(error), 1);
        chk("bad_hold", 32'(cpu_hold), 1);
        chk("bad_ready", 32'(byte_ready), 0);
        @(posedge clock); #1;
        check_two_word("bad", lb);

        // Oversize header
        lb = wlog.size();
        do_start();
        q = '{8'h01, 8'h01};
        send_stream(q, 0);
        @(negedge clock);
        chk("over_error", 32'(error), 1);
        repeat (4) @(posedge clock);
        #1;
        chk("over_wcount", 32'(wlog.size() - lb), 0);

        // Empty load
        lb = wlog.size();
        do_start();
        q = '{8'h00, 8'h00, 8'h00};
        send_stream(q, 0);
        @(negedge clock);
        chk("empty_done", 32'(done), 1);
        chk("empty_wcount", 32'(wlog.size() - lb), 0);
        @(posedge clock); #1;

        // Irregular source
        lb = wlog.size();
        do_start();
        send_stream(tw, 5);
        @(negedge clock);
        chk("irr_done", 32'(done), 1);
        @(posedge clock); #1;
        check_two_word("irr", lb);

        // Reset mid-load
        lb = wlog.size();
        do_start();
        for (int i = 0; i < 6; i++) send_byte(tw[i]);
        chk("pre_reset_write", 32'(mem_write), 1);
        reset_n = 0;
        #1;
        chk("mid_rst_byte_ready", 32'(byte_ready), 0);
        chk("mid_rst_mem_write", 32'(mem_write), 0);
        chk("mid_rst_cpu_hold", 32'(cpu_hold), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_error", 32'(error), 0);
        chk("mid_rst_mem_address", mem_address, BASE);
        chk("mid_rst_mem_data", mem_data, 0);
        @(posedge clock); #1;
        reset_n = 1;
        repeat (3) begin @(posedge clock); #1; end
        chk("rst_wcount", 32'(wlog.size() - lb), 0);

        // Restart with start pulses during DATA
        lb = wlog.size();
        do_start();
        foreach (tw[i]) begin
            if (i == 4 || i == 7) start = 1;
            send_byte(tw[i]);
            start = 0;
        end
        @(negedge clock);
        chk("restart_done", 32'(done), 1);
        @(posedge clock); #1;
        check_two_word("restart", lb);

        // Full-depth load
        lb = wlog.size();
        w = {};
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
        build(w, 0, q);
        do_start();
        send_stream(q, 0);
        @(negedge clock);
        chk("full_done", 32'(done), 1);
        @(posedge clock); #1;
        chk("full_wcount", 32'(wlog.size() - lb), 32'(DEPTH));
        if (wlog.size() - lb == DEPTH)
            chk("full_last_addr", wlog[lb+DEPTH-1][63:32], 32'h0040_03FC);

        // Random loads
        for (int it = 0; it < 12; it++) begin
            lb = wlog.size();
            n = $urandom_range(5, 0);
            bad = ($urandom_range(3, 0) == 0);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            build(w, bad, q);
            do_start();
            send_stream(q, $urandom_range(3, 0));
            @(negedge clock);
            chk("rnd_done", 32'(done), 32'(!bad));
            chk("rnd_error", 32'(error), 32'(bad));
            @(posedge clock); #1;
            chk("rnd_wcount", 32'(wlog.size() - lb), 32'(n));
        end

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
